multicycle_control_fsm: RTL and testbench

- Main control FSM for the multicycle datapath; sits directly upstream of the ALU.
- Sequences fetch/decode/execute/memory/writeback for each instruction and drives the ALU 3-bit select code.
- Drives all datapath mux selects and write strobes, and handshakes with instruction/data memory via mem_ready.
- Detects illegal opcodes/functs and memory timeouts.

---
 rtl/multicycle_control_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
//==============================================================================
// Module      : multicycle_control_fsm
// Description : Main control FSM of the multicycle datapath. Sequences each
//               instruction, drives the ALU select and the datapath controls,
//               and flags illegal instructions and memory handshake timeouts.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [2:0] alu_select,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_xor   = 6'b100110;
    localparam logic [7:0] c_wlast    = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [5:0] r_op_q;
    logic [5:0] r_funct_q;
    logic [7:0] r_wcnt;
    state_t     w_dec_next;
    logic       w_mem_state;
    logic       w_timeout;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);
    assign w_timeout   = w_mem_state && !mem_ready && (r_wcnt == c_wlast);
    assign state       = r_state;

    always_comb begin
        w_dec_next = S_ILLEGAL;
        case (opcode)
            c_op_lw, c_op_sw: w_dec_next = S_MEMADR;
            c_op_rtype: begin
                if (funct == c_fn_add || funct == c_fn_sub || funct == c_fn_and ||
                    funct == c_fn_or  || funct == c_fn_xor)
                    w_dec_next = S_EXECUTE;
            end
            c_op_beq:                       w_dec_next = S_BRANCH;
            c_op_j:                         w_dec_next = S_JUMP;
            c_op_addi, c_op_andi, c_op_ori: w_dec_next = S_IMM_EXEC;
            default:                        w_dec_next = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_op_q    <= '0;
            r_funct_q <= '0;
            r_wcnt    <= '0;
        end else begin
            // Counter is zero whenever a memory state is entered, since every
            // other state (and every completion or timeout) clears it.
            if (w_mem_state && !mem_ready && !w_timeout)
                r_wcnt <= r_wcnt + 8'd1;
            else
                r_wcnt <= '0;

            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op_q    <= opcode;
                    r_funct_q <= funct;
                    r_state   <= w_dec_next;
                end
                S_MEMADR:   r_state <= (r_op_q == c_op_sw) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: begin
                    if (mem_ready)      r_state <= S_MEMWB;
                    else if (w_timeout) r_state <= S_FETCH;
                end
                S_MEMWRITE: if (mem_ready || w_timeout) r_state <= S_FETCH;
                S_EXECUTE:  r_state <= S_ALUWB;
                S_IMM_EXEC: r_state <= S_IMM_WB;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        alu_select    = 3'b000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_op    = 1'b0;
        bus_err       = w_timeout;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                alu_select = 3'b010;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_select = 3'b010;
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_select = 3'b010;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                case (r_funct_q)
                    c_fn_sub: alu_select = 3'b011;
                    c_fn_and: alu_select = 3'b000;
                    c_fn_or:  alu_select = 3'b001;
                    c_fn_xor: alu_select = 3'b100;
                    default:  alu_select = 3'b010;
                endcase
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_select    = 3'b101;
                pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                alu_select = 3'b110;
                pc_write   = 1'b1;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (r_op_q)
                    c_op_andi: alu_select = 3'b000;
                    c_op_ori:  alu_select = 3'b001;
                    default:   alu_select = 3'b010;
                endcase
            end
            S_IMM_WB:   reg_write  = 1'b1;
            S_ILLEGAL:  illegal_op = 1'b1;
            default: ;
        endcase
        // Reset silences every strobe so an abandoned instruction writes nothing.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            illegal_op    = 1'b0;
            bus_err       = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
//==============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Self-checking bench for multicycle_control_fsm against a
//               per-instruction cycle-trace model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_control_fsm;

    localparam int T = 4;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_J = 4, K_IMM = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    logic [2:0] alu_select;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, bus_err;
    logic [3:0] state;

    multicycle_control_fsm #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .alu_select(alu_select), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       a;
        logic [1:0] b;
        logic       pw, pwc, ps, iord, mrd, mwr, irw, rdst, m2r, rw, ill, be;
    } outs_t;

    typedef struct packed {
        logic       mr;
        logic [3:0] st;
        logic [5:0] op;
        logic [5:0] fn;
        outs_t      o;
    } cyc_t;

    outs_t act;
    assign act = {alu_select, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
                  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  illegal_op, bus_err};

    logic [7:0] strobes;
    assign strobes = {pc_write, pc_write_cond, ir_write, mem_read, mem_write,
                      reg_write, illegal_op, bus_err};

    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110}) ? K_R : K_ILL;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b001000, 6'b001100, 6'b001101: return K_IMM;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] rsel(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b011;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b100110: return 3'b100;
            default:   return 3'b010;
        endcase
    endfunction

    // Cycles in which opcode/funct are irrelevant get random values, so the
    // model also exercises the capture made during decode.
    task automatic push(input logic [3:0] st, input outs_t o, input logic mr);
        q.push_back({mr, st, 6'($urandom), 6'($urandom), o});
    endtask

    // Memory wait: 'lat' not-ready cycles before ready; lat >= T means timeout.
    task automatic mem_phase(input logic [3:0] st, input outs_t base, input int lat, output bit ok);
        outs_t o;
        logic  mr;
        ok = 1'b0;
        for (int k = 0; k < T; k++) begin
            o  = base;
            mr = (k == lat);
            if (mr && st == 4'd0) begin
                o.irw = 1'b1;
                o.pw  = 1'b1;
            end
            if (!mr && k == T - 1) o.be = 1'b1;
            push(st, o, mr);
            if (mr) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int lf, input int lm);
        outs_t o;
        bit    ok;
        int    k;
        o = '0; o.mrd = 1'b1; o.b = 2'b01; o.sel = 3'b010;
        mem_phase(4'd0, o, lf, ok);
        if (!ok) return;
        o = '0; o.b = 2'b11; o.sel = 3'b010;
        q.push_back({1'($urandom), 4'd1, op, fn, o});
        k = kind(op, fn);
        case (k)
            K_LW, K_SW: begin
                o = '0; o.a = 1'b1; o.b = 2'b10; o.sel = 3'b010;
                push(4'd2, o, 1'($urandom));
                o = '0; o.iord = 1'b1;
                if (k == K_LW) o.mrd = 1'b1; else o.mwr = 1'b1;
                mem_phase((k == K_LW) ? 4'd3 : 4'd5, o, lm, ok);
                if (ok && k == K_LW) begin
                    o = '0; o.m2r = 1'b1; o.rw = 1'b1;
                    push(4'd4, o, 1'($urandom));
                end
            end
            K_R: begin
                o = '0; o.a = 1'b1; o.sel = rsel(fn);
                push(4'd6, o, 1'($urandom));
                o = '0; o.rdst = 1'b1; o.rw = 1'b1;
                push(4'd7, o, 1'($urandom));
            end
            K_BEQ: begin
                o = '0; o.a = 1'b1; o.sel = 3'b101; o.pwc = 1'b1;
                push(4'd8, o, 1'($urandom));
            end
            K_J: begin
                o = '0; o.sel = 3'b110; o.pw = 1'b1;
                push(4'd9, o, 1'($urandom));
            end
            K_IMM: begin
                o = '0; o.a = 1'b1; o.b = 2'b10;
                o.sel = (op == 6'b001000) ? 3'b010 : (op == 6'b001100) ? 3'b000 : 3'b001;
                push(4'd10, o, 1'($urandom));
                o = '0; o.rw = 1'b1;
                push(4'd11, o, 1'($urandom));
            end
            default: begin
                o = '0; o.ill = 1'b1;
                push(4'd12, o, 1'($urandom));
            end
        endcase
    endtask

    task automatic test_reset();
        cyc_t e;
        rst = 1'b1; mem_ready = 1'b1; opcode = '0; funct = '0;
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if (state !== 4'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if (strobes !== 8'h00) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000000", strobes);
        end
        @(negedge clk);
        rst = 1'b0;
        // Abandon an add in EXECUTE with a two-cycle reset.
        build(6'b000000, 6'b100000, 0, 0);
        for (int i = 0; i < 2; i++) begin
            e = q.pop_front();
            opcode = e.op; funct = e.fn; mem_ready = e.mr; #1;
            checks++;
            if (state !== e.st || act !== e.o) begin
                errors++; $display("FAIL reset_pre st=%0d/%0d outs=%h/%h", state, e.st, act, e.o);
            end
            @(negedge clk);
        end
        q.delete();
        rst = 1'b1; mem_ready = 1'b1; #1;
        checks++;
        if (state !== 4'd6 || strobes !== 8'h00) begin
            errors++; $display("FAIL reset_mid: state %0d strobes %b expected 6 00000000", state, strobes);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0 || strobes !== 8'h00) begin
            errors++; $display("FAIL reset_fetch: state %0d strobes %b expected 0 00000000", state, strobes);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic play(input string name);
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            opcode = e.op; funct = e.fn; mem_ready = e.mr; #1;
            checks++;
            if (state !== e.st) begin
                errors++; $display("FAIL %s state: got %0d expected %0d", name, state, e.st);
            end
            checks++;
            if (act !== e.o) begin
                errors++; $display("FAIL %s outputs (state %0d): got %h expected %h", name, e.st, act, e.o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype_add();
        build(6'b000000, 6'b100000, 0, 0);
        play("rtype_add");
    endtask

    task automatic test_lw_wait();
        build(6'b100011, 6'h15, 0, 3);
        build(6'b101011, 6'h2a, 1, 2);
        play("lw_sw_wait");
    endtask

    task automatic test_branch_jump();
        build(6'b000100, 6'h3f, 0, 0);
        build(6'b000010, 6'h00, 0, 0);
        build(6'b001101, 6'h11, 0, 0);
        play("branch_jump");
    endtask

    task automatic test_illegal();
        build(6'b111111, 6'b100000, 0, 0);
        build(6'b000000, 6'b000111, 0, 0);
        play("illegal");
    endtask

    task automatic test_timeout();
        build(6'b000000, 6'b100010, T, 0);
        build(6'b000000, 6'b100110, T - 1, 0);
        build(6'b100011, 6'h00, 0, T);
        build(6'b101011, 6'h00, 2, T + 2);
        play("timeout");
    endtask

    task automatic test_random();
        logic [5:0] ops [0:8];
        logic [5:0] fns [0:4];
        logic [5:0] op, fn;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
        ops[6] = 6'b001100; ops[7] = 6'b001101; ops[8] = 6'b000000;
        fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
        fns[3] = 6'b100101; fns[4] = 6'b100110;
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            build(op, fn, $urandom_range(0, 5), $urandom_range(0, 5));
        end
        play("random");
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_lw_wait();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
